jt49_eg_sched: RTL and testbench

- Envelope scheduler for the PSG envelope generator `jt49_eg`.
- Decodes CPU writes to envelope registers 11 (period fine), 12 (period coarse) and 13 (shape).
- Runs the prescaler and the 16-bit period counter.
- Drives the generator's step enable (`eg_cen`), `restart` and `ctrl` inputs with correct timing, so the generator advances one step per envelope period.

---
 rtl/jt49_eg_sched_if.sv | 25 ++
 rtl/jt49_eg_sched.sv | 101 ++++++++++
 tb/tb_jt49_eg_sched.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/jt49_eg_sched_if.sv
// CPU-side register bus for the jt49 envelope scheduler.
// master: CPU / bench side, slave: jt49_eg_sched.
interface jt49_eg_sched_if;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] din;
    logic [3:0] rd_addr;
    logic [7:0] dout;

    modport master (
        output wr,
        output addr,
        output din,
        output rd_addr,
        input  dout
    );

    modport slave (
        input  wr,
        input  addr,
        input  din,
        input  rd_addr,
        output dout
    );
endinterface

// File: rtl/jt49_eg_sched.sv
// Envelope scheduler for jt49_eg: decodes envelope registers 11/12/13, runs the
// cen prescaler and the period counter, and produces eg_cen / eg_restart / eg_ctrl.
// Optional register readback on dout is enabled by defining JT49_EG_RDBK_EN.
// Register 11/12 map to period[7:0]/period[15:8], so PW is expected to be 16.
module jt49_eg_sched #(
    parameter int unsigned PRESCALE = 16,
    parameter int unsigned PW       = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    jt49_eg_sched_if.slave bus,
    output logic           eg_cen,
    output logic           eg_restart,
    output logic [3:0]     eg_ctrl,
    output logic [PW-1:0]  period
);
    localparam int unsigned    PSW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0] PRE_LAST = PSW'(PRESCALE - 1);

    logic [PSW-1:0] pre_cnt;
    logic [PW-1:0]  per_cnt;
    logic [PW-1:0]  eff_period;
    logic [PW:0]    cnt_inc;
    logic           wr_shape;
    logic           tick;
    logic           step;

    // Tick/step decode; a shape write suppresses any step in the same clk.
    always_comb begin
        wr_shape   = bus.wr && (bus.addr == 4'd13);
        tick       = cen && (pre_cnt == PRE_LAST);
        eff_period = (period == '0) ? PW'(1) : period;
        // One extra bit so cnt+1 never wraps before the compare.
        cnt_inc    = {1'b0, per_cnt} + (PW+1)'(1);
        step       = tick && !wr_shape && (cnt_inc >= {1'b0, eff_period});
    end

    // Prescaler and period counter; shape writes restart the whole period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            per_cnt <= '0;
        end else if (wr_shape) begin
            pre_cnt <= '0;
            per_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            per_cnt <= step ? '0 : cnt_inc[PW-1:0];
        end else if (cen) begin
            pre_cnt <= pre_cnt + PSW'(1);
        end
    end

    // Register writes; period updates are seen by the counter from the next clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period  <= '0;
            eg_ctrl <= '0;
        end else if (bus.wr) begin
            case (bus.addr)
                4'd11:   period[7:0]  <= bus.din;
                4'd12:   period[15:8] <= bus.din;
                4'd13:   eg_ctrl      <= bus.din[3:0];
                default: ;
            endcase
        end
    end

    // Step strobe and restart: restart is held until it has overlapped one eg_cen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eg_cen     <= 1'b0;
            eg_restart <= 1'b0;
        end else begin
            eg_cen <= step;
            if (wr_shape) begin
                eg_restart <= 1'b1;
            end else if (eg_cen) begin
                eg_restart <= 1'b0;
            end
        end
    end

`ifdef JT49_EG_RDBK_EN
    // Combinational register readback.
    always_comb begin
        case (bus.rd_addr)
            4'd11:   bus.dout = period[7:0];
            4'd12:   bus.dout = period[15:8];
            4'd13:   bus.dout = {4'b0000, eg_ctrl};
            default: bus.dout = 8'h00;
        endcase
    end
`else
    assign bus.dout = 8'h00;
    logic unused_rd_addr;
    assign unused_rd_addr = ^bus.rd_addr;
`endif

endmodule

// File: tb/tb_jt49_eg_sched.sv
// Directed bench for jt49_eg_sched: expected eg_cen edge numbers are queued when
// stimulus is applied and checked by a monitor whenever eg_cen is seen high.
module tb_jt49_eg_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        eg_cen;
    logic        eg_restart;
    logic [3:0]  eg_ctrl;
    logic [15:0] period;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    int exp_q[$];
    int gaps;

    jt49_eg_sched_if bus_if ();

    jt49_eg_sched #(
        .PRESCALE (16),
        .PW       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .bus        (bus_if),
        .eg_cen     (eg_cen),
        .eg_restart (eg_restart),
        .eg_ctrl    (eg_ctrl),
        .period     (period)
    );

    always #5 clk = ~clk;

    // Rising-edge counter: value N after edge N.
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Return 1 time unit after rising edge n.
    task automatic goto(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write presented so that it is sampled at rising edge w.
    task automatic write_at(input int w, input logic [3:0] a, input logic [7:0] d);
        goto(w - 1);
        bus_if.wr   = 1'b1;
        bus_if.addr = a;
        bus_if.din  = d;
        goto(w);
        bus_if.wr   = 1'b0;
    endtask

    // Scoreboard: each eg_cen must match the next queued edge number.
    always @(negedge clk) begin
        if (eg_cen) begin
            int e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            check("eg_cen_edge", edge_n, e);
        end
    end

    initial begin
        bus_if.wr      = 1'b0;
        bus_if.addr    = 4'd0;
        bus_if.din     = 8'd0;
        bus_if.rd_addr = 4'd0;

        // Reset state, then period 0: step every 16 cen.
        #2;
        check("rst_eg_cen", eg_cen, 0);
        check("rst_restart", eg_restart, 0);
        check("rst_period", period, 0);
        goto(2);
        rst = 1'b0;
        exp_q.push_back(18);
        exp_q.push_back(34);
        exp_q.push_back(50);
        exp_q.push_back(66);
        goto(20);
        check("p0_restart", eg_restart, 0);
        check("p0_ctrl", eg_ctrl, 0);
        goto(70);

        // Period 3, shape E.
        write_at(71, 4'd11, 8'h03);
        write_at(72, 4'd12, 8'h00);
        exp_q.push_back(121);
        exp_q.push_back(169);
        exp_q.push_back(217);
        write_at(73, 4'd13, 8'h0E);
        check("p3_restart_rise", eg_restart, 1);
        check("p3_ctrl", eg_ctrl, 4'hE);
        check("p3_period", period, 3);
        bus_if.rd_addr = 4'd11;
        #1;
`ifdef JT49_EG_RDBK_EN
        check("rdbk_11", bus_if.dout, 8'h03);
`else
        check("rdbk_11", bus_if.dout, 8'h00);
`endif
        bus_if.rd_addr = 4'd13;
        #1;
`ifdef JT49_EG_RDBK_EN
        check("rdbk_13", bus_if.dout, 8'h0E);
`else
        check("rdbk_13", bus_if.dout, 8'h00);
`endif
        goto(120);
        check("p3_restart_held", eg_restart, 1);
        goto(121);
        check("p3_restart_with_cen", eg_restart, 1);
        goto(122);
        check("p3_restart_fall", eg_restart, 0);

        // Period 16 up to cnt=12, then drop period to 5.
        write_at(220, 4'd11, 8'h10);
        exp_q.push_back(425);
        exp_q.push_back(505);
        exp_q.push_back(585);
        write_at(410, 4'd11, 8'h05);

        // Shape write on the same edge as a step-producing tick.
        exp_q.push_back(745);
        write_at(665, 4'd13, 8'h0A);
        check("coinc_restart", eg_restart, 1);
        goto(700);
        check("coinc_restart_gap", eg_restart, 1);
        check("coinc_ctrl", eg_ctrl, 4'hA);
        goto(746);
        check("coinc_restart_fall", eg_restart, 0);

        // Period 1, two shape writes 5 clk apart.
        write_at(750, 4'd11, 8'h01);
        exp_q.push_back(776);
        exp_q.push_back(792);
        exp_q.push_back(808);
        write_at(755, 4'd13, 8'h08);
        gaps = 0;
        for (int c = 755; c <= 759; c++) begin
            goto(c);
            if (eg_restart !== 1'b1) gaps++;
        end
        write_at(760, 4'd13, 8'h0D);
        for (int c = 760; c <= 776; c++) begin
            goto(c);
            if (eg_restart !== 1'b1) gaps++;
        end
        check("dbl_restart_gaps", gaps, 0);
        check("dbl_ctrl", eg_ctrl, 4'hD);
        goto(777);
        check("dbl_restart_fall", eg_restart, 0);

        // Async reset mid-period with restart pending.
        write_at(820, 4'd13, 8'h03);
        bus_if.rd_addr = 4'd12;
        goto(830);
        check("pre_rst_restart", eg_restart, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_eg_cen", eg_cen, 0);
        check("arst_restart", eg_restart, 0);
        check("arst_ctrl", eg_ctrl, 0);
        check("arst_period", period, 0);
        check("arst_rdbk_12", bus_if.dout, 8'h00);
        goto(833);
        rst = 1'b0;
        exp_q.push_back(849);
        exp_q.push_back(865);
        goto(848);
        check("post_rst_restart", eg_restart, 0);
        goto(870);

        // cen held low: no steps, writes still land.
        cen = 1'b0;
        write_at(875, 4'd11, 8'h07);
        check("cen0_period", period, 7);
        goto(920);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
